// File: rtl/demux_edge_counter.sv
// Monitors the demux output lines: synchronises them, counts rising edges per channel
// with saturating counters, decodes the single active channel and serves count reads.
module demux_edge_counter #(
    parameter int unsigned NCH   = 8,
    parameter int unsigned SEL_W = 3,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   din,
    input  logic             clear,
    input  logic             rd_req,
    input  logic [SEL_W-1:0] rd_ch,
    output logic             rd_ack,
    output logic [CNT_W-1:0] rd_data,
    output logic             rd_sat,
    output logic [SEL_W-1:0] active_ch,
    output logic             active_valid,
    output logic             err_multi
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_RESP    = 2'd2
    } rd_state_e;

    logic [NCH-1:0]   s1_q, s2_q, s3_q;
    logic [NCH-1:0]   rise;
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];
    logic [NCH-1:0]   sat_q, sat_d;

    logic             hot_one, hot_multi, hot_single;
    logic [SEL_W-1:0] hot_idx;
    logic             active_valid_q;
    logic [SEL_W-1:0] active_ch_q;
    logic             err_multi_q, err_multi_d;

    rd_state_e        state_q, state_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic             rd_sat_q, rd_sat_d;
    logic             rd_ack_q, rd_ack_d;
    logic [CNT_W-1:0] sel_cnt;
    logic             sel_sat;

    // Two-flop synchroniser plus history flop for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= din;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;

    // Saturating edge counters; clear overrides any same-cycle edge
    always_comb begin
        sat_d = sat_q;
        for (int unsigned k = 0; k < NCH; k++) begin
            cnt_d[k] = cnt_q[k];
        end
        if (clear) begin
            sat_d = '0;
            for (int unsigned k = 0; k < NCH; k++) begin
                cnt_d[k] = '0;
            end
        end else begin
            for (int unsigned k = 0; k < NCH; k++) begin
                if (rise[k]) begin
                    if (cnt_q[k] != CNT_MAX) begin
                        cnt_d[k] = cnt_q[k] + CNT_W'(1);
                    end
                    if (cnt_q[k] >= CNT_PRE) begin
                        sat_d[k] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_q <= '0;
            for (int unsigned k = 0; k < NCH; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            sat_q <= sat_d;
            for (int unsigned k = 0; k < NCH; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    always_comb begin
        hot_one   = 1'b0;
        hot_multi = 1'b0;
        hot_idx   = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (s2_q[k]) begin
                if (hot_one) begin
                    hot_multi = 1'b1;
                end
                hot_one = 1'b1;
                hot_idx = SEL_W'(k);
            end
        end
    end

    assign hot_single  = hot_one & ~hot_multi;
    assign err_multi_d = clear ? 1'b0 : (err_multi_q | hot_multi);

    // active_ch keeps its last one-hot index while idle or multi-hot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_valid_q <= 1'b0;
            active_ch_q    <= '0;
            err_multi_q    <= 1'b0;
        end else begin
            active_valid_q <= hot_single;
            err_multi_q    <= err_multi_d;
            if (hot_single) begin
                active_ch_q <= hot_idx;
            end
        end
    end

    // Out-of-range channel indices match no counter and read back as zero
    always_comb begin
        sel_cnt = '0;
        sel_sat = 1'b0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (ch_q == SEL_W'(k)) begin
                sel_cnt = cnt_q[k];
                sel_sat = sat_q[k];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        rd_data_d = rd_data_q;
        rd_sat_d  = rd_sat_q;
        rd_ack_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rd_req) begin
                    ch_d    = rd_ch;
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                rd_data_d = sel_cnt;
                rd_sat_d  = sel_sat;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                rd_ack_d = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ch_q      <= '0;
            rd_data_q <= '0;
            rd_sat_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            rd_data_q <= rd_data_d;
            rd_sat_q  <= rd_sat_d;
            rd_ack_q  <= rd_ack_d;
        end
    end

    assign rd_ack       = rd_ack_q;
    assign rd_data      = rd_data_q;
    assign rd_sat       = rd_sat_q;
    assign active_ch    = active_ch_q;
    assign active_valid = active_valid_q;
    assign err_multi    = err_multi_q;

endmodule

// File: doc/demux_edge_counter.md
Name: demux_edge_counter

Overview:
- Downstream monitor for the 1-to-8 demultiplexer outputs.
- Synchronises the NCH demux output lines to clk and counts rising edges per channel with saturating counters.
- Reports which single channel is currently active, and flags illegal multi-hot conditions.
- Provides a request/acknowledge readout port so a bench or host can read any channel count.

Parameters:
- NCH, 8, number of monitored channels (demux outputs); must be ≤ 2^SEL_W.
- SEL_W, 3, width of channel index fields.
- CNT_W, 8, width of each per-channel edge counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- din  input  NCH  demux outputs; din[k] = ok; asynchronous to clk.
- clear  input  1  synchronous pulse; zeroes counts, saturation flags and err_multi.
- rd_req  input  1  read request, level-sampled.
- rd_ch  input  SEL_W  channel to read, sampled with rd_req.
- rd_ack  output  1  one-cycle pulse; rd_data and rd_sat are valid in this cycle.
- rd_data  output  CNT_W  captured count of the requested channel.
- rd_sat  output  1  captured saturation flag of the requested channel.
- active_ch  output  SEL_W  index of the single high synchronised channel.
- active_valid  output  1  high when exactly one synchronised channel is high.
- err_multi  output  1  sticky flag: two or more synchronised channels were high in the same cycle.

Behaviour:
- Reset (async): sync flops, edge-history flops, all counters and sat flags, rd_ack, rd_data, rd_sat, active_ch, active_valid and err_multi = 0. FSM = IDLE.
- Synchronisation: 2-flop synchroniser per bit (s1, s2), plus history flop s3.
  - rise[k] = s2[k] & ~s3[k].
  - A din edge sampled at posedge N appears in s2 after N+1.
  - The count increments at posedge N+2.
  - A pulse narrower than one clk period may be missed; this is not an error.
- Counters:
  - On rise[k], cnt[k] increments by 1.
  - At all-ones the counter holds, and sat[k] is set and stays set until clear or reset.
  - Channels count independently; simultaneous rises on several channels all increment in the same cycle.
- clear:
  - Next cycle, all cnt = 0, sat = 0, err_multi = 0.
  - clear and rise in the same cycle: clear wins, count = 0.
  - Sync/history flops are not cleared, so no spurious edge is generated.
- Active decode (registered from s2, valid one cycle after s2 update):
  - Exactly one bit set: active_valid = 1 and active_ch = index.
  - Zero bits set: active_valid = 0 and active_ch holds its last value.
  - Two or more bits set: active_valid = 0, active_ch holds, and err_multi is set (sticky).
- Read FSM, states IDLE, CAPTURE, RESP:
  - IDLE: if rd_req = 1, latch rd_ch and go to CAPTURE.
  - CAPTURE: rd_data <= cnt[latched ch] and rd_sat <= sat[latched ch]. The registered value at this edge excludes any increment occurring in the same cycle. Go to RESP.
  - RESP: rd_ack = 1 for exactly one cycle, then go to IDLE.
  - Latency: rd_req sampled at posedge N gives rd_ack high after posedge N+2.
  - rd_req held high re-issues a read every 3 cycles; rd_req and rd_ch are ignored outside IDLE.
  - Out-of-range rd_ch (≥ NCH): rd_data = 0 and rd_sat = 0, with normal ack timing.
  - clear during CAPTURE: the captured value is the pre-clear count.
  - clear during RESP: rd_data is unaffected.
  - rd_data and rd_sat hold their values between reads.
- Reset mid-read: FSM returns to IDLE immediately and rd_ack drops asynchronously; no ack is produced for the aborted request.

Test Plan:
- Reset, then hold din = 0 for 20 cycles → all outputs 0; a read of ch 0 returns rd_data = 0 with rd_ack exactly 2 cycles after rd_req.
- Walk sel 0..7, driving 5 pulses of 4 clk width on each channel → reads of every channel return 5, active_ch tracks the channel with active_valid = 1, and err_multi stays 0.
- 300 rising edges on din[3] with CNT_W = 8 → cnt[3] = 255 and rd_sat = 1; clear → read returns 0 and rd_sat = 0.
- din = 8'b0001_0010 for 3 cycles → active_valid = 0 and err_multi = 1; err_multi remains 1 after din returns to one-hot, until clear.
- Rising edge on ch 2 in the same cycle as clear → read of ch 2 returns 0; the next edge makes it 1.
- rd_req held high for 9 cycles → exactly 3 rd_ack pulses; assert reset while in CAPTURE → rd_ack never pulses for that request, and all counts are 0.
